// File: rtl/dma_job_scheduler.sv
// rtl/dma_job_scheduler.sv - one-job-at-a-time ring scheduler that programs engine_core registers
module dma_job_scheduler #(
  parameter int unsigned RING_BYTES     = 4096,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] src_base_cfg,
  input  logic [31:0] dest_base_cfg,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [31:0] job_size,
  output logic        done_valid,
  output logic        done_err,
  output logic        busy,
  input  logic [31:0] tail_ptr,
  input  logic [31:0] ctrl_stat,
  output logic [31:0] reg_wr_data,
  output logic [5:0]  reg_wr_en
);
  localparam logic [3:0] ST_INIT_SRC  = 4'd0;
  localparam logic [3:0] ST_INIT_DST  = 4'd1;
  localparam logic [3:0] ST_INIT_TAIL = 4'd2;
  localparam logic [3:0] ST_INIT_CTRL = 4'd3;
  localparam logic [3:0] ST_IDLE      = 4'd4;
  localparam logic [3:0] ST_WR_SIZE   = 4'd5;
  localparam logic [3:0] ST_WR_TAIL   = 4'd6;
  localparam logic [3:0] ST_WR_HEAD   = 4'd7;
  localparam logic [3:0] ST_WR_CTRL   = 4'd8;
  localparam logic [3:0] ST_WAIT_INTR = 4'd9;
  localparam logic [3:0] ST_ACK       = 4'd10;
  localparam logic [3:0] ST_DONE      = 4'd11;
  localparam logic [3:0] ST_REJECT    = 4'd12;
  localparam logic [3:0] ST_ABORT     = 4'd13;
  localparam logic [3:0] ST_FAULT     = 4'd14;
  localparam logic [3:0] ST_HALT      = 4'd15;

  localparam logic [32:0] RING_LIMIT = 33'(RING_BYTES);
  localparam bit          WD_ON      = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] WD_LAST    = WD_ON ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  logic [3:0]  state;
  logic [31:0] size_q;
  logic [31:0] head_q;
  logic [31:0] wd_cnt;
  logic        wrap_q;
  logic        accept;
  logic        size_bad;
  logic [32:0] sum;
  logic        unused_stat;

  assign accept      = (state == ST_IDLE) && job_valid && job_ready;
  assign sum         = {1'b0, tail_ptr} + {1'b0, job_size};
  assign size_bad    = (job_size == 32'd0) || ({1'b0, job_size} > RING_LIMIT);
  assign unused_stat = ^ctrl_stat[30:0];

  // Every output is a pure register: each state schedules the strobe that is seen one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_INIT_SRC;
      size_q      <= '0;
      head_q      <= '0;
      wd_cnt      <= '0;
      wrap_q      <= 1'b0;
      job_ready   <= 1'b0;
      done_valid  <= 1'b0;
      done_err    <= 1'b0;
      busy        <= 1'b0;
      reg_wr_data <= '0;
      reg_wr_en   <= '0;
    end else begin
      reg_wr_en   <= '0;
      reg_wr_data <= '0;
      done_valid  <= 1'b0;
      done_err    <= 1'b0;
      job_ready   <= 1'b0;
      case (state)
        ST_INIT_SRC: begin
          reg_wr_en   <= 6'b000001;
          reg_wr_data <= src_base_cfg;
          state       <= ST_INIT_DST;
        end
        ST_INIT_DST: begin
          reg_wr_en   <= 6'b000010;
          reg_wr_data <= dest_base_cfg;
          state       <= ST_INIT_TAIL;
        end
        ST_INIT_TAIL: begin
          reg_wr_en <= 6'b000100;
          state     <= ST_INIT_CTRL;
        end
        ST_INIT_CTRL: begin
          reg_wr_en <= 6'b100000;
          state     <= ST_IDLE;
        end
        ST_IDLE: begin
          if (accept) begin
            size_q <= job_size;
            busy   <= 1'b1;
            if (size_bad) begin
              state <= ST_REJECT;
            end else begin
              // A job that would run past the window restarts at offset 0.
              wrap_q <= (sum > RING_LIMIT);
              head_q <= (sum > RING_LIMIT) ? job_size : sum[31:0];
              state  <= ST_WR_SIZE;
            end
          end else begin
            job_ready <= 1'b1;
          end
        end
        ST_WR_SIZE: begin
          reg_wr_en   <= 6'b010000;
          reg_wr_data <= size_q;
          state       <= wrap_q ? ST_WR_TAIL : ST_WR_HEAD;
        end
        ST_WR_TAIL: begin
          reg_wr_en <= 6'b000100;
          state     <= ST_WR_HEAD;
        end
        ST_WR_HEAD: begin
          reg_wr_en   <= 6'b001000;
          reg_wr_data <= head_q;
          state       <= ST_WR_CTRL;
        end
        ST_WR_CTRL: begin
          reg_wr_en   <= 6'b100000;
          reg_wr_data <= 32'd1;
          wd_cnt      <= '0;
          state       <= ST_WAIT_INTR;
        end
        ST_WAIT_INTR: begin
          if (ctrl_stat[31]) begin
            state <= ST_ACK;
          end else if (WD_ON && (wd_cnt == WD_LAST)) begin
            state <= ST_ABORT;
          end else begin
            wd_cnt <= wd_cnt + 32'd1;
          end
        end
        ST_ACK: begin
          reg_wr_en <= 6'b100000;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          done_valid <= 1'b1;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
        ST_REJECT: begin
          done_valid <= 1'b1;
          done_err   <= 1'b1;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
        ST_ABORT: begin
          reg_wr_en <= 6'b100000;
          state     <= ST_FAULT;
        end
        ST_FAULT: begin
          done_valid <= 1'b1;
          done_err   <= 1'b1;
          busy       <= 1'b0;
          state      <= ST_HALT;
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_INIT_SRC;
      endcase
    end
  end
endmodule

// File: tb/tb_dma_job_scheduler.sv
// tb/tb_dma_job_scheduler.sv - randomized bench for dma_job_scheduler with an engine model and cycle scoreboard
module tb_dma_job_scheduler;
  localparam int TMO = 16;
  localparam int INF = 1000000000;

  typedef struct packed {
    logic [5:0]  en;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] src_base_cfg = 32'h1000;
  logic [31:0] dest_base_cfg = 32'h2000;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [31:0] job_size = '0;
  logic        done_valid;
  logic        done_err;
  logic        busy;
  logic [31:0] tail_ptr;
  logic [31:0] ctrl_stat;
  logic [31:0] reg_wr_data;
  logic [5:0]  reg_wr_en;

  dma_job_scheduler #(.RING_BYTES(4096), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .src_base_cfg(src_base_cfg), .dest_base_cfg(dest_base_cfg),
    .job_valid(job_valid), .job_ready(job_ready), .job_size(job_size),
    .done_valid(done_valid), .done_err(done_err), .busy(busy),
    .tail_ptr(tail_ptr), .ctrl_stat(ctrl_stat),
    .reg_wr_data(reg_wr_data), .reg_wr_en(reg_wr_en)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: expected strobes and completions keyed by the cycle they must be visible.
  logic [5:0]  exp_en  [int];
  logic [31:0] exp_dat [int];
  bit          exp_done[int];
  bit          exp_err [int];
  int ready_from = INF;
  int busy_from = 0;
  int busy_to = -1;
  wr_t plan_q[$];

  // Engine model: latches writes, raises the interrupt irq_delay cycles after enable lands.
  logic [31:0] e_src, e_dst, e_tail, e_head, e_size, e_ctrl;
  int          irq_at;
  int          irq_delay = 5;
  bit          tail_load = 1'b0;
  logic [31:0] tail_preset = '0;
  assign tail_ptr  = e_tail;
  assign ctrl_stat = e_ctrl;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e_src <= '0; e_dst <= '0; e_tail <= '0; e_head <= '0; e_size <= '0; e_ctrl <= '0;
      irq_at <= -1;
    end else begin
      if (tail_load) e_tail <= tail_preset;
      if (reg_wr_en[0]) e_src  <= reg_wr_data;
      if (reg_wr_en[1]) e_dst  <= reg_wr_data;
      if (reg_wr_en[2]) e_tail <= reg_wr_data;
      if (reg_wr_en[3]) e_head <= reg_wr_data;
      if (reg_wr_en[4]) e_size <= reg_wr_data;
      if (reg_wr_en[5]) begin
        e_ctrl <= reg_wr_data;
        irq_at <= reg_wr_data[0] ? cyc + irq_delay : -1;
      end else if (e_ctrl[0] && !e_ctrl[31] && (cyc + 1 == irq_at)) begin
        e_tail     <= e_tail + e_size;
        e_ctrl[31] <= 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired at cyc %0d", nm, cyc);
  endtask

  int          c_n;
  logic [5:0]  c_en;
  bit          c_done;
  always @(negedge clk) begin
    c_n    = cyc;
    c_en   = exp_en.exists(c_n) ? exp_en[c_n] : 6'd0;
    c_done = exp_done.exists(c_n) ? exp_done[c_n] : 1'b0;
    chk("reg_wr_en", {26'd0, reg_wr_en}, {26'd0, c_en});
    if (c_en != 6'd0) chk("reg_wr_data", reg_wr_data, exp_dat[c_n]);
    chk("done_valid", {31'd0, done_valid}, {31'd0, c_done});
    if (c_done) chk("done_err", {31'd0, done_err}, {31'd0, exp_err[c_n]});
    chk("busy", {31'd0, busy}, {31'd0, (c_n >= busy_from) && (c_n <= busy_to)});
    chk("job_ready", {31'd0, job_ready}, {31'd0, c_n >= ready_from});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference rule for one job: the register writes it must produce, or a reject.
  task automatic plan(input logic [31:0] s, input logic [31:0] t, output bit rej);
    longint sum;
    plan_q.delete();
    rej = (s == 0) || (s > 4096);
    if (!rej) begin
      sum = longint'(t) + longint'(s);
      plan_q.push_back({6'h10, s});
      if (sum > 4096) begin
        plan_q.push_back({6'h04, 32'd0});
        plan_q.push_back({6'h08, s});
      end else begin
        plan_q.push_back({6'h08, 32'(sum)});
      end
      plan_q.push_back({6'h20, 32'd1});
    end
  endtask

  task automatic do_reset(input bit pre);
    int r;
    if (pre) chk("pre_rst_en", {26'd0, reg_wr_en}, {26'd0, exp_en.exists(cyc) ? exp_en[cyc] : 6'd0});
    rst = 1'b1;
    #1;
    chk("rst_en", {26'd0, reg_wr_en}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done_valid}, 32'd0);
    chk("rst_ready", {31'd0, job_ready}, 32'd0);
    exp_en.delete(); exp_dat.delete(); exp_done.delete(); exp_err.delete();
    ready_from = INF; busy_from = 0; busy_to = -1;
    tick();
    tick();
    rst = 1'b0;
    r = cyc;
    exp_en[r+1] = 6'h01; exp_dat[r+1] = src_base_cfg;
    exp_en[r+2] = 6'h02; exp_dat[r+2] = dest_base_cfg;
    exp_en[r+3] = 6'h04; exp_dat[r+3] = 32'd0;
    exp_en[r+4] = 6'h20; exp_dat[r+4] = 32'd0;
    ready_from = r + 5;
  endtask

  task automatic set_tail(input logic [31:0] v);
    tail_preset = v;
    tail_load = 1'b1;
    tick();
    tail_load = 1'b0;
  endtask

  task automatic run_job(input logic [31:0] s, input int d, input int gap, input bit early, input int rst_at);
    int t0, k, c, w;
    bit rej;
    logic [31:0] t;
    t0 = cyc;
    while (cyc < ready_from + gap - (early ? 1 : 0)) begin
      if (cyc - t0 > 3000) begin bound_fail("ready_wait"); return; end
      tick();
    end
    job_valid = 1'b1; job_size = s; irq_delay = d;
    while (cyc < ready_from) begin
      if (cyc - t0 > 3000) begin bound_fail("accept_wait"); job_valid = 1'b0; return; end
      tick();
    end
    k = cyc;
    t = e_tail;
    tick();
    job_valid = 1'b0;
    job_size = $urandom;
    plan(s, t, rej);
    busy_from = k + 1;
    if (rej) begin
      exp_done[k+2] = 1'b1; exp_err[k+2] = 1'b1;
      busy_to = k + 1; ready_from = k + 3;
    end else begin
      foreach (plan_q[i]) begin
        exp_en[k+2+i] = plan_q[i].en;
        exp_dat[k+2+i] = plan_q[i].d;
      end
      c = k + 1 + plan_q.size();
      if (d < TMO) begin
        w = c + d;
        exp_en[w+2] = 6'h20; exp_dat[w+2] = 32'd0;
        exp_done[w+3] = 1'b1; exp_err[w+3] = 1'b0;
        busy_to = w + 2; ready_from = w + 4;
      end else begin
        exp_en[c+TMO+1] = 6'h20; exp_dat[c+TMO+1] = 32'd0;
        exp_done[c+TMO+2] = 1'b1; exp_err[c+TMO+2] = 1'b1;
        busy_to = c + TMO + 1; ready_from = INF;
      end
    end
    if (rst_at >= 0) begin
      while (cyc < k + rst_at) tick();
      do_reset(1'b1);
    end
  endtask

  initial begin
    bit rej;
    int sel;
    logic [31:0] s;
    plan(100, 0, rej);
    chk("pin_plain_rej", {31'd0, rej}, 32'd0);
    chk("pin_plain_n", plan_q.size(), 3);
    chk("pin_plain_head", plan_q[1].d, 100);
    plan(200, 4000, rej);
    chk("pin_wrap_n", plan_q.size(), 4);
    chk("pin_wrap_head", plan_q[2].d, 200);
    plan(100, 3996, rej);
    chk("pin_edge_head", plan_q[1].d, 4096);
    plan(0, 0, rej);
    chk("pin_zero_rej", {31'd0, rej}, 32'd1);
    plan(4097, 0, rej);
    chk("pin_big_rej", {31'd0, rej}, 32'd1);

    #1;
    do_reset(1'b0);
    while (cyc < ready_from) tick();
    chk("eng_src", e_src, 32'h1000);
    chk("eng_dst", e_dst, 32'h2000);

    run_job(100, 4, 0, 0, -1);
    set_tail(4000);
    run_job(200, 3, 0, 0, -1);
    set_tail(3996);
    run_job(100, 2, 0, 0, -1);
    run_job(4, 15, 0, 1, -1);
    run_job(0, 5, 0, 1, -1);
    run_job(5000, 5, 0, 0, -1);
    run_job(4096, 6, 1, 0, -1);
    run_job(4097, 6, 0, 0, -1);
    set_tail(32'hFFFF_FFF0);
    run_job(100, 7, 0, 0, -1);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0: s = 0;
        1: s = 4096;
        2: s = 4097 + $urandom_range(0, 100);
        3: s = $urandom;
        4: s = 4096 - e_tail;
        default: s = $urandom_range(1, 4096);
      endcase
      run_job(s, $urandom_range(2, TMO - 1), $urandom_range(0, 2), 1'($urandom_range(0, 1)), -1);
    end

    run_job(300, 5, 0, 0, 2);
    run_job(64, 10, 0, 0, 6);
    run_job(128, 1000, 0, 0, -1);
    repeat (40) tick();
    do_reset(1'b1);
    run_job(10, 3, 0, 0, -1);
    for (int i = 0; i < 100 && cyc <= ready_from + 3; i++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
